wb_ram_slave: RTL
=================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: memory size in 32-bit words; a power of two, at most 2^30.
REQ-002 SHALL have parameter WAIT_STATES, default 1: extra cycles (0..15) inserted before the first ACK of each cycle.
REQ-003 SHALL have ports clk (input, 1): single clock; all logic on the rising edge.
REQ-004 SHALL have port rst (input, 1): reset, asynchronous and active-high.
REQ-005 SHALL have ports STB (input, 1) and CYC (input, 1): Wishbone strobe and cycle.
REQ-006 SHALL have port WE (input, 1): write enable.
REQ-007 SHALL have port ADR (input, 32): byte address; ADR[1:0] ignored; word index is ADR[log2(DEPTH)+1:2].
REQ-008 SHALL have ports DAT_I (input, 32) and DAT_O (output, 32): write data in and read data out.
REQ-009 SHALL have port CTI_I (input, 3): cycle type; 3'b010 is an incrementing burst, 3'b111 is end-of-burst, all other codes are classic.
REQ-010 SHALL have ports ACK (output, 1), ERR (output, 1) and RTY (output, 1): termination signals; RTY is tied to 0.

Function
REQ-011 SHALL implement states IDLE, WAIT, CLASSIC_ACK and BURST; state, ACK, ERR and DAT_O are all registered.
REQ-012 IDLE: STB&CYC SHALL latch the word index, go to WAIT if WAIT_STATES>0, otherwise go to CLASSIC_ACK (classic CTI) or BURST (CTI=010).
REQ-013 WAIT: SHALL count WAIT_STATES cycles, then enter CLASSIC_ACK or BURST according to the CTI_I latched in IDLE.
REQ-014 First-ACK latency SHALL be exactly 1+WAIT_STATES cycles after STB&CYC is first sampled in IDLE.
REQ-015 CLASSIC_ACK: SHALL assert ACK for exactly one cycle, then return to IDLE; STB is not resampled until IDLE.
REQ-016 BURST: SHALL assert ACK on every cycle in which STB&CYC is high, with no further wait states.
REQ-017 BURST: each ACKed beat SHALL increment the internal word index by 1, and DAT_O SHALL present the next word on the following cycle.
REQ-018 BURST, STB low with CYC high: SHALL deassert ACK on the next cycle, hold the index and keep the state.
REQ-019 BURST: an ACKed beat with CTI_I=111 SHALL be the final beat; the block then returns to IDLE and ACK is 0 on the next cycle.
REQ-020 Write: on an ACKed beat with WE=1, mem[index] SHALL take DAT_I; read-during-write returns the old data on DAT_O.
REQ-021 Read: DAT_O SHALL hold mem[index] in every cycle ACK=1; outside ACK, DAT_O keeps its last value.
REQ-022 CYC dropping in any state other than IDLE SHALL abort the cycle: IDLE on the next cycle, ACK=0, and no write for the aborted beat.
REQ-023 Index wrap: with the macro absent, an index of DEPTH-1 SHALL increment to 0.
REQ-024 Write-then-read to the same address SHALL return the new data.

Reset
REQ-025 rst high SHALL immediately force state=IDLE, ACK=0, ERR=0, DAT_O=0 and the wait counter to 0.
REQ-026 Memory contents SHALL NOT be reset.
REQ-027 Reset asserted mid-burst SHALL drop ACK in the same cycle without any further write.

Configuration
REQ-028 Macro WB_RAM_SLAVE_ERR_EN defined: any beat whose ADR[31:2] is at or beyond DEPTH SHALL assert ERR instead of ACK.
REQ-029 With WB_RAM_SLAVE_ERR_EN defined, an out-of-range beat SHALL perform no write, drive DAT_O=0 and return to IDLE; ERR and ACK are never both 1.
REQ-030 Macro WB_RAM_SLAVE_ERR_EN absent: ADR upper bits SHALL be ignored, the address aliases modulo DEPTH and ERR is tied to 0.

Verification
REQ-031 Classic write: WAIT_STATES=1, write 0xDEADBEEF to ADR 0x10, then read ADR 0x10 -> each ACK 2 cycles after STB; DAT_O=0xDEADBEEF.
REQ-032 Burst read: 4 beats from ADR 0x100, CTI 010,010,010,111, with words 0x100..0x10C preloaded -> ACK high 4 consecutive cycles; DAT_O in preload order; ACK=0 after the last beat.
REQ-033 Burst stall: STB low for 2 cycles after beat 2 -> ACK low for those 2 cycles; beat 3 returns word 0x108.
REQ-034 Wrap: DEPTH=16, 2-beat burst from ADR 0x3C -> data from word 15, then word 0.
REQ-035 Abort: CYC dropped after 1 beat of a write burst -> only word 0 is written; IDLE next cycle.
REQ-036 With WB_RAM_SLAVE_ERR_EN defined, DEPTH=16, read ADR 0x40 -> ERR pulse, ACK=0, DAT_O=0; memory unchanged.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone RAM slave: classic and incrementing-burst cycles with WAIT_STATES leading wait cycles.
// Define WB_RAM_SLAVE_ERR_EN to terminate beats beyond DEPTH with ERR instead of aliasing.
module wb_ram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        STB,
    input  logic        CYC,
    input  logic        WE,
    input  logic [31:0] ADR,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    input  logic [2:0]  CTI_I,
    output logic        ACK,
    output logic        ERR,
    output logic        RTY
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef WB_RAM_SLAVE_ERR_EN
    localparam int IW = 30;
`else
    localparam int IW = AW;
`endif

    typedef enum logic [1:0] {IDLE, WAIT, CLASSIC_ACK, BURST} state_t;

    state_t        r_state, w_state_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_burst, w_burst_nxt;
    logic [3:0]    r_cnt, w_cnt_nxt;
    logic          r_ack, w_ack_nxt;
    logic          r_err, w_err_nxt;
    logic [31:0]   r_dat, w_dat_nxt;
    logic          w_go;
    logic          w_oor;
    logic          w_mem_we;
    logic [31:0]   r_mem [DEPTH];
    logic          w_unused;

    assign w_unused = ^ADR;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_burst_nxt = r_burst;
        w_cnt_nxt   = r_cnt;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_dat_nxt   = r_dat;
        w_mem_we    = 1'b0;
        w_go        = 1'b0;
        w_oor       = 1'b0;

        case (r_state)
            IDLE: begin
                if (STB && CYC) begin
                    w_idx_nxt   = ADR[IW+1:2];
                    w_burst_nxt = (CTI_I == 3'b010);
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_STATES - 1);
                    end else begin
                        w_go = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!CYC) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_go = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            CLASSIC_ACK: begin
                w_state_nxt = IDLE;
                w_mem_we    = r_ack && CYC && WE;
            end
            BURST: begin
                if (!CYC) begin
                    w_state_nxt = IDLE;
                end else if (STB) begin
                    // r_ack && STB is a completed beat; STB without r_ack resumes after a stall
                    if (r_ack) begin
                        w_mem_we = WE;
                        if (CTI_I == 3'b111) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_idx_nxt = r_idx + IW'(1);
                            w_go      = 1'b1;
                        end
                    end else begin
                        w_go = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

`ifdef WB_RAM_SLAVE_ERR_EN
        w_oor = (w_idx_nxt >> AW) != '0;
`endif

        if (w_go) begin
            if (w_oor) begin
                // error slot reuses CLASSIC_ACK so the held STB is not resampled
                w_state_nxt = CLASSIC_ACK;
                w_err_nxt   = 1'b1;
                w_dat_nxt   = '0;
            end else begin
                w_state_nxt = w_burst_nxt ? BURST : CLASSIC_ACK;
                w_ack_nxt   = 1'b1;
                w_dat_nxt   = r_mem[w_idx_nxt[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_burst <= 1'b0;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_burst <= w_burst_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            r_dat   <= w_dat_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[r_idx[AW-1:0]] <= DAT_I;
        end
    end

    assign DAT_O = r_dat;
    assign ACK   = r_ack;
    assign ERR   = r_err;
    assign RTY   = 1'b0;
endmodule
